// File: rtl/demux32_pkg.sv
// Shared constants for the four-lane routing demultiplexer.
package demux32_pkg;

    localparam logic [1:0] LANE_A = 2'b00;
    localparam logic [1:0] LANE_B = 2'b01;
    localparam logic [1:0] LANE_C = 2'b10;
    localparam logic [1:0] LANE_D = 2'b11;

    localparam int NUM_LANES     = 4;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux_lane_fifo.sv
// One lane buffer: small circular FIFO with a zero-when-empty head output.
module demux_lane_fifo
    import demux32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == FULL_COUNT);
    // A full lane never accepts, even if it pops in the same cycle.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & valid & ~flush;
    assign head    = valid ? mem_reg[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux32.sv
// Four-lane routing demultiplexer: lane-select decode, in_ready mux and lane wiring.
module demux32
    import demux32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [3:0]       lane_full
);

    logic [3:0]       push_lane;
    logic [WIDTH-1:0] head [NUM_LANES];

    // Ready depends only on registered fullness and flush, never on out_ready.
    assign in_ready = ~lane_full[in_sel] & ~flush;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign push_lane[gi] = in_valid & in_ready & (in_sel == 2'(gi));

            demux_lane_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .push      (push_lane[gi]),
                .push_data (in_data),
                .pop       (out_ready[gi]),
                .head      (head[gi]),
                .valid     (out_valid[gi]),
                .full      (lane_full[gi])
            );
        end
    endgenerate

    assign out_a = head[LANE_A];
    assign out_b = head[LANE_B];
    assign out_c = head[LANE_C];
    assign out_d = head[LANE_D];

endmodule

// File: tb/tb_demux32.sv
// Scoreboard bench for demux32: per-lane expected-word queues checked against lane heads.
module tb_demux32;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [3:0]       lane_full;

    logic [WIDTH-1:0] exp_q [4][$];
    int vectors;
    int miscompares;

    demux32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lane_full (lane_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane_out(input int i);
        case (i)
            0:       return out_a;
            1:       return out_b;
            2:       return out_c;
            default: return out_d;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
    endtask

    // Drive one cycle of stimulus, check all outputs against the model, then clock.
    task automatic cycle(input logic iv, input logic [1:0] sel, input logic [31:0] data,
                         input logic [3:0] ordy, input logic fl);
        logic exp_ready;
        logic [WIDTH-1:0] exp_head;
        in_valid  = iv;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ready = (exp_q[sel].size() != DEPTH) && !fl;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        for (int i = 0; i < 4; i++) begin
            exp_head = (exp_q[i].size() > 0) ? exp_q[i][0] : '0;
            check_eq($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(exp_q[i].size() > 0));
            check_eq($sformatf("lane_full[%0d]", i), 32'(lane_full[i]), 32'(exp_q[i].size() == DEPTH));
            check_eq($sformatf("head[%0d]", i), lane_out(i), exp_head);
        end
        if (fl) begin
            clear_model();
        end else begin
            for (int i = 0; i < 4; i++)
                if (ordy[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
            if (iv && exp_ready) exp_q[sel].push_back(data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] ordy);
        cycle(1'b0, 2'b00, 32'h0, ordy, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 2'b00;
        in_data = '0; out_ready = 4'b0000;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset then idle
        idle(4'b0000);

        // single route to lane c
        cycle(1'b1, 2'b10, 32'hDEADBEEF, 4'b0000, 1'b0);
        check_eq("single_route_c", out_c, 32'hDEADBEEF);
        check_eq("single_route_valid", 32'(out_valid), 32'h4);
        idle(4'b0100);

        // backpressure on lane a
        cycle(1'b1, 2'b00, 32'd1, 4'b0000, 1'b0);
        cycle(1'b1, 2'b00, 32'd2, 4'b0000, 1'b0);
        cycle(1'b1, 2'b00, 32'd3, 4'b0000, 1'b0);
        check_eq("bp_full", 32'(lane_full), 32'h1);
        cycle(1'b1, 2'b00, 32'd3, 4'b0001, 1'b0);
        check_eq("bp_second", out_a, 32'd2);
        idle(4'b0001);
        check_eq("bp_empty", 32'(out_valid[0]), 32'h0);

        // simultaneous push and pop on lane b
        cycle(1'b1, 2'b01, 32'hB0B0_0001, 4'b0000, 1'b0);
        cycle(1'b1, 2'b01, 32'hB0B0_0002, 4'b0010, 1'b0);
        check_eq("pushpop_b", out_b, 32'hB0B0_0002);
        check_eq("pushpop_notfull", 32'(lane_full[1]), 32'h0);
        idle(4'b0010);

        // lane independence: d full, a still accepts
        cycle(1'b1, 2'b11, 32'hD000_0001, 4'b0000, 1'b0);
        cycle(1'b1, 2'b11, 32'hD000_0002, 4'b0000, 1'b0);
        cycle(1'b1, 2'b00, 32'hA000_0001, 4'b0000, 1'b0);
        check_eq("indep_d", out_d, 32'hD000_0001);
        check_eq("indep_a", out_a, 32'hA000_0001);

        // flush with push and pops pending
        cycle(1'b1, 2'b01, 32'hB000_0009, 4'b0000, 1'b0);
        cycle(1'b1, 2'b10, 32'hC000_0009, 4'b0000, 1'b0);
        cycle(1'b1, 2'b01, 32'h1111_2222, 4'b1111, 1'b1);
        check_eq("flush_valid", 32'(out_valid), 32'h0);
        check_eq("flush_full", 32'(lane_full), 32'h0);
        idle(4'b0000);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0));
        end

        // asynchronous reset mid-traffic, no clock edge
        cycle(1'b1, 2'b00, 32'h5555_0001, 4'b0000, 1'b0);
        cycle(1'b1, 2'b11, 32'h5555_0002, 4'b0000, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'h0);
        check_eq("arst_full", 32'(lane_full), 32'h0);
        check_eq("arst_out_a", out_a, 32'h0);
        check_eq("arst_out_d", out_d, 32'h0);
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 2'b11, 32'h7777_0001, 4'b0000, 1'b0);
        check_eq("post_rst_d", out_d, 32'h7777_0001);
        idle(4'b1000);
        idle(4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
